// File: rtl/uart_tx.sv
// uart_tx: 8-bit UART transmitter; ports clk, rst (sync active-high), data_i/valid_i/ready_o accept handshake, tx_o registered serial line (idle high), busy_o frame in progress; define UART_TX_PARITY_EN for an even-parity bit (8E1, 11-bit frame), otherwise 8N1
module uart_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       tx_o,
  output logic       busy_o
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0] idx, idx_nxt;
  logic [7:0] shreg, shreg_nxt;
  logic tx_nxt, bit_done;
  assign ready_o = state == IDLE && !rst;
  assign busy_o = state != IDLE && !rst;
  assign bit_done = cnt == LAST;
  always_ff @(posedge clk) state <= rst ? IDLE : state_nxt;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
      shreg <= '0;
      tx_o <= 1'b1;
    end else begin
      cnt <= cnt_nxt;
      idx <= idx_nxt;
      shreg <= shreg_nxt;
      tx_o <= tx_nxt;
    end
  end
  always_comb begin
    state_nxt = state;
    cnt_nxt = (state == IDLE || bit_done) ? '0 : cnt + CW'(1);
    idx_nxt = idx;
    shreg_nxt = shreg;
    tx_nxt = tx_o;
    case (state)
      IDLE: if (valid_i) begin
        state_nxt = START;
        shreg_nxt = data_i;
        tx_nxt = 1'b0;
      end
      START: if (bit_done) begin
        state_nxt = DATA;
        tx_nxt = shreg[idx];
      end
      DATA: if (bit_done) begin
        idx_nxt = idx + 3'd1;
`ifdef UART_TX_PARITY_EN
        state_nxt = idx == 3'd7 ? PARITY : DATA;
        tx_nxt = idx == 3'd7 ? ^shreg : shreg[idx_nxt];
`else
        state_nxt = idx == 3'd7 ? STOP : DATA;
        tx_nxt = idx == 3'd7 ? 1'b1 : shreg[idx_nxt];
`endif
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_done) begin
        state_nxt = STOP;
        tx_nxt = 1'b1;
      end
`endif
      STOP: if (bit_done) begin
        state_nxt = IDLE;
        tx_nxt = 1'b1;
      end
      default: begin
        state_nxt = IDLE;
        tx_nxt = 1'b1;
      end
    endcase
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: table-driven and randomized check of uart_tx serial frames, handshake and reset behaviour
module tb_uart_tx;
  localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] data_i = '0;
  logic valid_i = 1'b0;
  logic ready_o, tx_o, busy_o;
  int vectors = 0;
  int miscompares = 0;
  typedef struct {
    logic [7:0] data;
    logic [1:0] mode;
    int gap;
    logic [10:0] frame;
  } vec_t;
  vec_t tbl[6];
  uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk),
    .rst(rst),
    .data_i(data_i),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .tx_o(tx_o),
    .busy_o(busy_o)
  );
  always #5 clk = ~clk;
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    logic [10:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = ((b >> i) % 2) != 0;
`ifdef UART_TX_PARITY_EN
    f[9] = ($countones(b) % 2) != 0;
`endif
    f[NB-1] = 1'b1;
    return f;
  endfunction
  task automatic check(input string nm, input logic act, input logic want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s at %0t: got %b want %b", nm, $time, act, want);
    end
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      valid_i = 1'b0;
      data_i = 8'($urandom);
      #1;
      check("idle_tx", tx_o, 1'b1);
      check("idle_ready", ready_o, 1'b1);
    end
  endtask
  // mode 0: valid dropped after accept, 1: random valid/data noise, 2: valid and data held
  task automatic send(input logic [7:0] b, input logic [1:0] mode, input logic [10:0] f);
    @(negedge clk);
    valid_i = 1'b1;
    data_i = b;
    #1;
    check("pre_ready", ready_o, 1'b1);
    check("pre_tx", tx_o, 1'b1);
    for (int c = 0; c < NB * CPB; c++) begin
      @(negedge clk);
      if (mode == 2'd1) begin
        valid_i = 1'($urandom);
        data_i = 8'($urandom);
      end else if (mode == 2'd0) valid_i = 1'b0;
      #1;
      check("frame_tx", tx_o, f[c / CPB]);
      check("frame_ready", ready_o, 1'b0);
      check("frame_busy", busy_o, 1'b1);
    end
  endtask
  initial begin
    logic [7:0] b;
    logic [10:0] f0;
    tbl[0] = '{8'h5D, 2'd0, 3, frame_of(8'h5D)};
    tbl[1] = '{8'hA5, 2'd2, 2, frame_of(8'hA5)};
    tbl[2] = '{8'h3C, 2'd2, 0, frame_of(8'h3C)};
    tbl[3] = '{8'h00, 2'd1, 2, frame_of(8'h00)};
    tbl[4] = '{8'h07, 2'd0, 1, frame_of(8'h07)};
    tbl[5] = '{8'h03, 2'd0, 0, frame_of(8'h03)};
    rst = 1'b1;
    valid_i = 1'b1;
    data_i = 8'h55;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_tx", tx_o, 1'b1);
      check("rst_ready", ready_o, 1'b0);
      check("rst_busy", busy_o, 1'b0);
    end
    rst = 1'b0;
    valid_i = 1'b0;
    #1;
    check("rel_ready", ready_o, 1'b1);
    check("rel_busy", busy_o, 1'b0);
    for (int i = 0; i < 6; i++) begin
      idle(tbl[i].gap);
      send(tbl[i].data, tbl[i].mode, tbl[i].frame);
    end
    idle(2);
    f0 = frame_of(8'h00);
    @(negedge clk);
    valid_i = 1'b1;
    data_i = 8'h00;
    for (int c = 0; c < 4 * CPB + 8; c++) begin
      @(negedge clk);
      valid_i = 1'b0;
      #1;
      check("abort_pre_tx", tx_o, f0[c / CPB]);
    end
    rst = 1'b1;
    #1;
    check("abort_ready", ready_o, 1'b0);
    @(negedge clk);
    check("abort_tx", tx_o, 1'b1);
    check("abort_busy", busy_o, 1'b0);
    rst = 1'b0;
    #1;
    check("abort_rel_ready", ready_o, 1'b1);
    idle(40);
    send(8'hFF, 2'd0, frame_of(8'hFF));
    for (int i = 0; i < 24; i++) begin
      b = 8'($urandom);
      idle($urandom_range(0, 3));
      send(b, 2'($urandom_range(0, 2)), frame_of(b));
    end
    idle(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, SHALL set the number of clk cycles per serial bit (100 MHz / 115200 baud); legal range 4..65535.
REQ-002 clk  input  1  SHALL be the single clock; all logic is rising-edge triggered.
REQ-003 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 data_i  input  8  SHALL carry the byte to transmit, sampled on acceptance.
REQ-005 valid_i  input  1  SHALL indicate that data_i holds a byte to send.
REQ-006 ready_o  output  1  SHALL indicate that the block can accept a byte this cycle.
REQ-007 tx_o  output  1  SHALL be the serial line output; idle level high.
REQ-008 busy_o  output  1  SHALL be high while a frame is in progress.

Function
REQ-009 FSM states SHALL be IDLE, START, DATA, PARITY (macro only), STOP.
REQ-010 ready_o SHALL be 1 exactly when state is IDLE and rst is low; busy_o SHALL be its complement outside reset.
REQ-011 Acceptance SHALL occur on a rising edge where valid_i && ready_o; data_i SHALL be latched into an internal shift register on that edge.
REQ-012 On acceptance, IDLE->START; tx_o SHALL go low on that same edge, so latency from the accepting edge to the start bit is 0 cycles.
REQ-013 Each bit (start, data, parity, stop) SHALL hold tx_o stable for exactly CLKS_PER_BIT cycles, timed by a baud counter that restarts at 0 on every state entry.
REQ-014 DATA SHALL send 8 bits LSB first, using a 3-bit index that wraps 7->0 on the DATA exit transition.
REQ-015 STOP SHALL drive tx_o high for one bit time, then return to IDLE.
REQ-016 A byte held on valid_i at the end of STOP SHALL be accepted in the first IDLE cycle; the minimum inter-frame gap is 1 clk of idle-high.
REQ-017 valid_i and data_i changes while busy_o=1 SHALL be ignored and SHALL NOT corrupt the frame in flight.
REQ-018 tx_o SHALL be driven from a register; no combinational path from inputs to tx_o is permitted.
REQ-019 The baud counter SHALL be sized to $clog2(CLKS_PER_BIT) bits and SHALL NOT overflow.

Reset
REQ-020 While rst=1, on each edge: state=IDLE, tx_o=1, busy_o=0, baud counter=0, bit index=0, shift register=0.
REQ-021 rst asserted mid-frame SHALL abort the frame; tx_o SHALL be 1 on the edge after rst is sampled high, and no partial bits SHALL resume after release.
REQ-022 ready_o SHALL be 0 while rst=1 and SHALL be 1 on the first cycle after rst deasserts; valid_i during reset SHALL be ignored.

Configuration
REQ-023 Macro UART_TX_PARITY_EN defined: an even-parity bit (XOR of the 8 data bits) SHALL be sent in state PARITY between DATA and STOP, giving an 11-bit frame.
REQ-024 Macro UART_TX_PARITY_EN undefined: the PARITY state and its logic SHALL be absent, giving a 10-bit 8N1 frame with DATA->STOP.

Verification
REQ-025 rst held 5 cycles with valid_i=1 -> tx_o=1 and ready_o=0 throughout; ready_o=1 on the first cycle after release.
REQ-026 CLKS_PER_BIT=16, send 0x5D -> tx_o sequence 0,1,0,1,1,1,0,1,0,1 (start, LSB..MSB, stop), each bit exactly 16 cycles; ready_o low for 160 cycles.
REQ-027 Keep valid_i high and send 0xA5 then 0x3C back-to-back -> second start bit begins exactly 1 idle cycle after the first stop bit ends; both bytes decode correctly.
REQ-028 Toggle data_i and valid_i randomly while sending 0x00 -> the serialized byte is 0x00.
REQ-029 Assert rst for 1 cycle in the middle of data bit 3 -> tx_o=1 from the next edge; idle until a new valid_i; a following 0xFF frame is correct.
REQ-030 UART_TX_PARITY_EN defined, send 0x07 then 0x03 -> parity bits 1 then 0; frame length 176 cycles at CLKS_PER_BIT=16.
